// File: rtl/topk_insertion_sorter_if.sv
// rtl/topk_insertion_sorter_if.sv - sample input stream into the top-K sorter
interface topk_insertion_sorter_if #(
    parameter int DIST_W  = 18,
    parameter int CLASS_W = 2
);
    logic               in_valid;
    logic               in_ready;
    logic [DIST_W-1:0]  in_dist;
    logic [CLASS_W-1:0] in_class;
    logic               in_last;

    modport master (
        output in_valid, in_dist, in_class, in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_dist, in_class, in_last,
        output in_ready
    );
endinterface

// File: rtl/topk_insertion_sorter.sv
// rtl/topk_insertion_sorter.sv - streaming top-K smallest-distance selector feeding the voter
// Optional: define TOPK_SAMPLE_COUNT_EN to add the saturating per-frame sample_count output.
module topk_insertion_sorter #(
    parameter int K       = 5,
    parameter int DIST_W  = 18,
    parameter int CLASS_W = 2,
    parameter int ENTRY_W = DIST_W + CLASS_W
) (
    input  logic                   clk,
    input  logic                   rst,
    topk_insertion_sorter_if.slave s_in,
    output logic [K*ENTRY_W-1:0]   sorted_list,
    output logic                   out_valid,
`ifdef TOPK_SAMPLE_COUNT_EN
    output logic [15:0]            sample_count,
`endif
    output logic [2:0]             fill_count
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t state_q, state_d;
    logic   ready_q;
    logic   accept;

    logic [DIST_W-1:0]  dist_q [K];
    logic [CLASS_W-1:0] cls_q  [K];
    logic [K-1:0]       vld_q;

    logic [DIST_W-1:0]  ins_dist [K];
    logic [CLASS_W-1:0] ins_cls  [K];
    logic [K-1:0]       ins_vld;
    logic [K-1:0]       take;
    logic [K*ENTRY_W-1:0] ins_packed;
    logic [2:0]         ins_fill;

    assign s_in.in_ready = ready_q && (state_q != DONE);
    assign accept        = s_in.in_valid && s_in.in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = s_in.in_last ? DONE : ACCUM;
            ACCUM:   if (accept && s_in.in_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Slots are contiguous and ascending, so take[] is monotonic: the first set bit
    // is the insertion point and every later slot shifts down one rank.
    always_comb begin
        take       = '0;
        ins_packed = '0;
        ins_fill   = '0;
        for (int i = 0; i < K; i++) begin
            take[i] = !vld_q[i] || (dist_q[i] > s_in.in_dist);
        end
        ins_dist[0] = take[0] ? s_in.in_dist  : dist_q[0];
        ins_cls[0]  = take[0] ? s_in.in_class : cls_q[0];
        ins_vld[0]  = take[0] ? 1'b1          : vld_q[0];
        for (int i = 1; i < K; i++) begin
            if (take[i-1]) begin
                ins_dist[i] = dist_q[i-1];
                ins_cls[i]  = cls_q[i-1];
                ins_vld[i]  = vld_q[i-1];
            end else if (take[i]) begin
                ins_dist[i] = s_in.in_dist;
                ins_cls[i]  = s_in.in_class;
                ins_vld[i]  = 1'b1;
            end else begin
                ins_dist[i] = dist_q[i];
                ins_cls[i]  = cls_q[i];
                ins_vld[i]  = vld_q[i];
            end
        end
        for (int i = 0; i < K; i++) begin
            ins_packed[i*ENTRY_W +: ENTRY_W] = {ins_dist[i], ins_cls[i]};
            ins_fill = ins_fill + 3'(ins_vld[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q <= 1'b0;
            vld_q   <= '0;
            for (int i = 0; i < K; i++) begin
                dist_q[i] <= '0;
                cls_q[i]  <= '0;
            end
        end else begin
            ready_q <= 1'b1;
            if (state_q == DONE) begin
                vld_q <= '0;
                for (int i = 0; i < K; i++) begin
                    dist_q[i] <= '0;
                    cls_q[i]  <= '0;
                end
            end else if (accept) begin
                vld_q <= ins_vld;
                for (int i = 0; i < K; i++) begin
                    dist_q[i] <= ins_dist[i];
                    cls_q[i]  <= ins_cls[i];
                end
            end
        end
    end

    // Result is captured from the post-insertion view on the last-sample edge so it
    // is already stable during the single DONE cycle in which out_valid is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sorted_list <= '0;
            fill_count  <= '0;
            out_valid   <= 1'b0;
        end else begin
            out_valid <= accept && s_in.in_last;
            if (accept && s_in.in_last) begin
                sorted_list <= ins_packed;
                fill_count  <= ins_fill;
            end
        end
    end

`ifdef TOPK_SAMPLE_COUNT_EN
    logic [15:0] cnt_q;
    logic [15:0] cnt_inc;

    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            sample_count <= '0;
        end else begin
            if (state_q == DONE) cnt_q <= '0;
            else if (accept)     cnt_q <= cnt_inc;
            if (accept && s_in.in_last) sample_count <= cnt_inc;
        end
    end
`endif
endmodule

// File: tb/tb_topk_insertion_sorter.sv
// tb/tb_topk_insertion_sorter.sv - directed self-checking bench for topk_insertion_sorter
module tb_topk_insertion_sorter;
    localparam int K  = 5;
    localparam int DW = 18;
    localparam int CW = 2;
    localparam int EW = DW + CW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    topk_insertion_sorter_if #(.DIST_W(DW), .CLASS_W(CW)) bus ();

    logic [K*EW-1:0] sorted_list;
    logic            out_valid;
    logic [2:0]      fill_count;
`ifdef TOPK_SAMPLE_COUNT_EN
    logic [15:0]     sample_count;
`endif

    topk_insertion_sorter #(.K(K), .DIST_W(DW), .CLASS_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_in         (bus.slave),
        .sorted_list  (sorted_list),
        .out_valid    (out_valid),
`ifdef TOPK_SAMPLE_COUNT_EN
        .sample_count (sample_count),
`endif
        .fill_count   (fill_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] ent(input int d, input int c);
        return {d[DW-1:0], c[CW-1:0]};
    endfunction

    // Called on a negedge; returns on the negedge after the accepting posedge.
    task automatic send(input int d, input int c, input bit l);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_dist  = d[DW-1:0];
        bus.in_class = c[CW-1:0];
        bus.in_last  = l;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("ready_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic end_frame(input string tag, input logic [K*EW-1:0] exp, input logic [2:0] f);
        bus.in_valid = 1'b0;
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_list"}, sorted_list, exp);
        check({tag, "_fill"}, fill_count, f);
        @(negedge clk);
        check({tag, "_pulse_end"}, out_valid, 0);
        check({tag, "_hold"}, sorted_list, exp);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_dist  = '0;
        bus.in_class = '0;
        bus.in_last  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", bus.in_ready, 0);
        check("rst_valid", out_valid, 0);
        check("rst_fill", fill_count, 0);
        check("rst_list", sorted_list, 0);
        rst = 1'b1;
        #1 check("rel_ready_pre_clk", bus.in_ready, 0);
        @(negedge clk);
        check("rel_ready", bus.in_ready, 1);

        send(40, 0, 0); send(10, 1, 0); send(30, 2, 0); send(20, 3, 0); send(50, 0, 1);
        end_frame("t1", {ent(50, 0), ent(40, 0), ent(30, 2), ent(20, 3), ent(10, 1)}, 5);
`ifdef TOPK_SAMPLE_COUNT_EN
        check("t1_count", sample_count, 5);
`endif

        for (int d = 9; d >= 2; d--) send(d, d % 4, d == 2);
        end_frame("t2", {ent(6, 2), ent(5, 1), ent(4, 0), ent(3, 3), ent(2, 2)}, 5);
`ifdef TOPK_SAMPLE_COUNT_EN
        check("t2_count", sample_count, 8);
`endif

        send(5, 1, 0); send(5, 2, 0); send(5, 3, 1);
        end_frame("t3_ties", {ent(0, 0), ent(0, 0), ent(5, 3), ent(5, 2), ent(5, 1)}, 3);
        send(7, 2, 1);
        end_frame("t3_single", {ent(0, 0), ent(0, 0), ent(0, 0), ent(0, 0), ent(7, 2)}, 1);

        send(32'h3FFFF, 2, 1);
        end_frame("t6_max", {ent(0, 0), ent(0, 0), ent(0, 0), ent(0, 0), ent(32'h3FFFF, 2)}, 1);
`ifdef TOPK_SAMPLE_COUNT_EN
        check("t6_count", sample_count, 1);
`endif

        send(15, 1, 0); send(25, 2, 1);
        bus.in_valid = 1'b1;
        bus.in_dist  = 18'd5;
        bus.in_class = 2'd3;
        bus.in_last  = 1'b0;
        check("t4_done_ready", bus.in_ready, 0);
        check("t4a_valid", out_valid, 1);
        check("t4a_list", sorted_list, {ent(0, 0), ent(0, 0), ent(0, 0), ent(25, 2), ent(15, 1)});
        send(5, 3, 0); send(35, 0, 1);
        end_frame("t4b", {ent(0, 0), ent(0, 0), ent(0, 0), ent(35, 0), ent(5, 3)}, 2);

        send(7, 1, 0); send(3, 2, 0); send(9, 0, 0);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_fill", fill_count, 0);
        check("t5_rst_list", sorted_list, 0);
        check("t5_rst_ready", bus.in_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_no_pulse", out_valid, 0);
        send(100, 3, 0); send(300, 2, 0); send(200, 1, 0); send(0, 0, 0); send(400, 3, 1);
        end_frame("t5_frame", {ent(400, 3), ent(300, 2), ent(200, 1), ent(100, 3), ent(0, 0)}, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
